// File: rtl/voice_mix_accum.sv
// Sums N_SRC signed voice partials over one sound-period slot window, applies a
// master gain shift and queues the sample in a 2-deep valid/ready FIFO.
// Optional clamp to 16-bit range: define MIX_SATURATE_EN.
module voice_mix_accum #(
    parameter int N_SRC     = 4,
    parameter int ACC_START = 2,
    parameter int ACC_LEN   = 512,
    parameter int ACC_W     = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [15:0]          i_tp,
    input  logic [16*N_SRC-1:0]  i_samples,
    input  logic [3:0]           i_gain_shift,
    output logic [15:0]          o_sample,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [7:0]           o_drop_cnt
);

    localparam int          CLOSE    = ACC_START + ACC_LEN;
    localparam logic [15:0] TP_START = 16'(ACC_START);
    localparam logic [15:0] TP_CLOSE = 16'(CLOSE);

    logic                    tp_zero_s;
    logic                    in_window_s;
    logic                    at_close_s;
    logic                    close_s;
    logic                    push_s;
    logic                    pop_s;
    logic signed [ACC_W-1:0] sum_s;
    logic signed [ACC_W-1:0] acc_r;
    logic                    armed_r;
    logic                    frame_open_r;
    logic [15:0]             mixed_s;

    logic [15:0]             head_r;
    logic [15:0]             tail_r;
    logic [1:0]              count_r;
    logic                    valid_r;
    logic [7:0]              drop_r;
    logic [15:0]             head_nx_s;
    logic [15:0]             tail_nx_s;
    logic [1:0]              count_nx_s;
    logic                    valid_nx_s;
    logic [7:0]              drop_nx_s;

    // Decode the time position into clear / accumulate / close events.
    always_comb begin
        tp_zero_s   = (i_tp == 16'd0);
        in_window_s = (i_tp >= TP_START) && (i_tp < TP_CLOSE);
        at_close_s  = (i_tp == TP_CLOSE);
        close_s     = at_close_s && armed_r;
        // Only a frame that actually started at tp==0 is allowed to produce output.
        push_s      = close_s && frame_open_r;
        pop_s       = valid_r && i_ready;
    end

    // Sign-extended sum of all source partials for this cycle.
    always_comb begin
        sum_s = '0;
        for (int k = 0; k < N_SRC; k++) begin
            sum_s = sum_s + ACC_W'($signed(i_samples[16*k +: 16]));
        end
    end

`ifdef MIX_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32'sd32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32'sd32768);
    logic signed [ACC_W-1:0] shifted_s;

    // Gain shift followed by clamp into the signed 16-bit range.
    always_comb begin
        shifted_s = acc_r >>> i_gain_shift;
        if (shifted_s > SAT_MAX) begin
            mixed_s = 16'h7FFF;
        end else if (shifted_s < SAT_MIN) begin
            mixed_s = 16'h8000;
        end else begin
            mixed_s = shifted_s[15:0];
        end
    end
`else
    // Gain shift followed by two's-complement truncation to 16 bits.
    always_comb begin
        mixed_s = 16'(acc_r >>> i_gain_shift);
    end
`endif

    // Accumulator, close edge-detect and frame-valid tracking.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc_r        <= '0;
            armed_r      <= 1'b1;
            frame_open_r <= 1'b0;
        end else begin
            armed_r <= !at_close_s;
            if (tp_zero_s) begin
                acc_r        <= '0;
                frame_open_r <= 1'b1;
            end else if (close_s) begin
                acc_r        <= '0;
                frame_open_r <= 1'b0;
            end else if (in_window_s) begin
                acc_r <= acc_r + sum_s;
            end else begin
                acc_r <= acc_r;
            end
        end
    end

    // FIFO next state; head_r always holds the oldest entry so o_sample is a flop.
    always_comb begin
        head_nx_s  = head_r;
        tail_nx_s  = tail_r;
        count_nx_s = count_r;
        drop_nx_s  = drop_r;
        case (count_r)
            2'd0: begin
                if (push_s) begin
                    head_nx_s  = mixed_s;
                    count_nx_s = 2'd1;
                end else begin
                    count_nx_s = 2'd0;
                end
            end
            2'd1: begin
                if (push_s && pop_s) begin
                    head_nx_s = mixed_s;
                end else if (push_s) begin
                    tail_nx_s  = mixed_s;
                    count_nx_s = 2'd2;
                end else if (pop_s) begin
                    count_nx_s = 2'd0;
                end else begin
                    count_nx_s = 2'd1;
                end
            end
            2'd2: begin
                if (pop_s) begin
                    head_nx_s = tail_r;
                    if (push_s) begin
                        tail_nx_s  = mixed_s;
                        count_nx_s = 2'd2;
                    end else begin
                        count_nx_s = 2'd1;
                    end
                end else if (push_s) begin
                    if (drop_r != 8'hFF) begin
                        drop_nx_s = drop_r + 8'd1;
                    end else begin
                        drop_nx_s = drop_r;
                    end
                end else begin
                    count_nx_s = 2'd2;
                end
            end
            default: begin
                count_nx_s = 2'd0;
            end
        endcase
        valid_nx_s = (count_nx_s != 2'd0);
    end

    // FIFO storage, occupancy and drop counter registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            head_r  <= 16'd0;
            tail_r  <= 16'd0;
            count_r <= 2'd0;
            valid_r <= 1'b0;
            drop_r  <= 8'd0;
        end else begin
            head_r  <= head_nx_s;
            tail_r  <= tail_nx_s;
            count_r <= count_nx_s;
            valid_r <= valid_nx_s;
            drop_r  <= drop_nx_s;
        end
    end

    assign o_sample   = head_r;
    assign o_valid    = valid_r;
    assign o_drop_cnt = drop_r;

endmodule
